pd_sched: RTL and testbench

PD_SCHED -- requirements
Module: pd_sched

---
 rtl/pd_pkg.sv | 5 +
 rtl/pd_core.sv | 46 ++++
 rtl/pd_sched.sv | 97 +++++++++
 tb/tb_pd_sched.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pd_pkg.sv
// pd_pkg: shared FSM state type and default detector pattern for pd_sched.
package pd_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [5:0] PD_PATTERN = 6'b110110;
endpackage

// File: rtl/pd_core.sv
// pd_core: serial 6-bit pattern detector with history, bit count, match pulse and saturating match counter.
module pd_core
  import pd_pkg::*;
#(
  parameter logic [5:0] PATTERN = PD_PATTERN,
  parameter int         CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  output logic             pd_o,
  output logic [CNT_W-1:0] cnt_o
);
  logic [4:0]       r_hist;
  logic [2:0]       r_nbits;
  logic             r_pd;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       w_hist;
  logic             w_match;
  // only the five most recent bits are stored; the sixth is the incoming bit
  assign w_hist  = {r_hist, bit_i};
  assign w_match = en_i && w_hist == PATTERN && r_nbits >= 3'd5;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_hist  <= '0;
      r_nbits <= '0;
      r_pd    <= 1'b0;
      r_cnt   <= '0;
    end else if (clr_i) begin
      r_hist  <= '0;
      r_nbits <= '0;
      r_pd    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_pd <= w_match;
      if (en_i) begin
        r_hist  <= w_hist[4:0];
        r_nbits <= r_nbits == 3'd6 ? r_nbits : r_nbits + 3'd1;
      end
      if (w_match && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  assign pd_o  = r_pd;
  assign cnt_o = r_cnt;
endmodule

// File: rtl/pd_sched.sv
// pd_sched: round-robin scheduler sharing one serial pattern detector among N_REQ requesters.
// Defining PD_SCHED_TIMEOUT_EN ends a burst after TMO_CYCLES consecutive cycles without valid data.
module pd_sched
  import pd_pkg::*;
#(
  parameter int         N_REQ      = 4,
  parameter logic [5:0] PATTERN    = PD_PATTERN,
  parameter int         CNT_W      = 8,
  parameter int         TMO_CYCLES = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ-1:0]         data_i,
  input  logic [N_REQ-1:0]         valid_i,
  input  logic [N_REQ-1:0]         last_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic                     pd_o,
  output logic [$clog2(N_REQ)-1:0] id_o,
  output logic                     done_o,
  output logic [CNT_W-1:0]         cnt_o,
  output logic                     abort_o
);
  localparam int IW = $clog2(N_REQ);
  state_t           r_state, w_nxt;
  logic [IW-1:0]    r_ptr, r_id, w_win, w_k;
  logic [N_REQ-1:0] r_gnt;
  logic             r_abort, w_found, w_start, w_acc, w_last, w_drop, w_tmo;
  logic [CNT_W-1:0] w_cnt;
  assign w_start = r_state == IDLE && |req_i;
  assign w_acc   = r_state == RUN && valid_i[r_id];
  assign w_last  = w_acc && last_i[r_id];
  assign w_drop  = r_state == RUN && !req_i[r_id];
`ifdef PD_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYCLES + 1);
  logic [TW-1:0] r_tmo;
  assign w_tmo = r_state == RUN && !valid_i[r_id] && r_tmo == TW'(TMO_CYCLES - 1);
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) r_tmo <= '0;
    else        r_tmo <= (r_state == RUN && !valid_i[r_id]) ? r_tmo + 1'b1 : '0;
`else
  // timeout compiled out; the compare keeps TMO_CYCLES referenced and folds to 0
  assign w_tmo = TMO_CYCLES < 0;
`endif
  always_comb begin
    w_win   = r_ptr;
    w_found = 1'b0;
    w_k     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_k = IW'((int'(r_ptr) + i) % N_REQ);
      if (!w_found && req_i[w_k]) begin
        w_win   = w_k;
        w_found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_nxt;
  always_comb begin
    w_nxt = r_state == IDLE ? (|req_i ? RUN : IDLE) :
            r_state == RUN  ? ((w_last || w_drop || w_tmo) ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_ptr   <= '0;
      r_id    <= '0;
      r_gnt   <= '0;
      r_abort <= 1'b0;
    end else begin
      if (w_start) begin
        r_id  <= w_win;
        r_gnt <= N_REQ'(1) << w_win;
      end
      if (r_state == RUN && w_nxt == DONE) begin
        r_gnt   <= '0;
        r_abort <= !w_last;
      end
      if (r_state == DONE) r_ptr <= int'(r_id) == N_REQ - 1 ? '0 : r_id + 1'b1;
    end
  always_comb begin
    done_o  = r_state == DONE;
    abort_o = done_o && r_abort;
    cnt_o   = done_o ? w_cnt : '0;
  end
  assign gnt_o = r_gnt;
  assign id_o  = r_id;
  pd_core #(.PATTERN(PATTERN), .CNT_W(CNT_W)) u_core (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (r_state == IDLE),
    .en_i  (w_acc),
    .bit_i (data_i[r_id]),
    .pd_o  (pd_o),
    .cnt_o (w_cnt)
  );
endmodule

// File: tb/tb_pd_sched.sv
// tb_pd_sched: directed self-checking bench for pd_sched (N_REQ=4, PATTERN=110110).
module tb_pd_sched;
  logic       clk_i = 1'b0, rst_i = 1'b0;
  logic [3:0] req_i = '0, data_i = '0, valid_i = '0, last_i = '0;
  logic [3:0] gnt_o;
  logic       pd_o, done_o, abort_o;
  logic [1:0] id_o;
  logic [7:0] cnt_o;
  logic [5:0] pat6 = 6'b110110;
  logic [8:0] pat9 = 9'b110110110;
  int n_tot = 0, n_bad = 0;
  pd_sched dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .last_i  (last_i),
    .gnt_o   (gnt_o),
    .pd_o    (pd_o),
    .id_o    (id_o),
    .done_o  (done_o),
    .cnt_o   (cnt_o),
    .abort_o (abort_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic send(input int k, input logic b, input logic l);
    valid_i = 4'b1 << k;
    data_i  = 4'(b) << k;
    last_i  = 4'(l) << k;
    tick();
    valid_i = '0;
    data_i  = '0;
    last_i  = '0;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_gnt", gnt_o, 0);
    chk("rst_pd", pd_o, 0);
    chk("rst_id", id_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_cnt", cnt_o, 0);
    chk("rst_abort", abort_o, 0);
    rst_i = 1'b1;
    // single match on requester 2
    req_i = 4'b0100;
    tick();
    chk("t1_gnt", gnt_o, 4'b0100);
    chk("t1_id", id_o, 2);
    for (int i = 0; i < 6; i++) begin
      send(2, pat6[5-i], i == 5);
      chk($sformatf("t1_pd%0d", i), pd_o, 32'(i == 5));
    end
    chk("t1_done", done_o, 1);
    chk("t1_cnt", cnt_o, 1);
    chk("t1_abort", abort_o, 0);
    chk("t1_gnt_off", gnt_o, 0);
    chk("t1_id_done", id_o, 2);
    req_i = '0;
    tick();
    chk("t1_pd_idle", pd_o, 0);
    chk("t1_done_idle", done_o, 0);
    // overlapping matches on requester 0
    req_i = 4'b0001;
    tick();
    chk("t2_gnt", gnt_o, 4'b0001);
    for (int i = 0; i < 9; i++) begin
      send(0, pat9[8-i], i == 8);
      chk($sformatf("t2_pd%0d", i), pd_o, 32'(i == 5 || i == 8));
    end
    chk("t2_done", done_o, 1);
    chk("t2_cnt", cnt_o, 2);
    req_i = '0;
    tick();
    // round robin with all requesting
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    req_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t3_gnt%0d", k), gnt_o, 32'(4'b1 << (k % 4)));
      send(k % 4, 1'b1, 1'b1);
      chk($sformatf("t3_done%0d", k), done_o, 1);
      chk($sformatf("t3_off%0d", k), gnt_o, 0);
      tick();
      chk($sformatf("t3_gap%0d", k), gnt_o, 0);
    end
    req_i = '0;
    tick();
    // requester drops mid-burst
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    req_i = 4'b0001;
    tick();
    chk("t4_gnt", gnt_o, 4'b0001);
    send(0, 1'b1, 1'b0);
    send(0, 1'b1, 1'b0);
    send(0, 1'b0, 1'b0);
    req_i = 4'b1110;
    tick();
    chk("t4_done", done_o, 1);
    chk("t4_abort", abort_o, 1);
    chk("t4_cnt", cnt_o, 0);
    tick();
    tick();
    chk("t4_next_gnt", gnt_o, 4'b0010);
    chk("t4_next_id", id_o, 1);
    req_i = '0;
    tick();
    tick();
    // reset mid-burst clears history
    req_i = 4'b0001;
    tick();
    chk("t5_gnt", gnt_o, 4'b0001);
    for (int i = 0; i < 5; i++) send(0, pat6[5-i], 1'b0);
    rst_i = 1'b0;
    #1;
    chk("t5_rst_gnt", gnt_o, 0);
    chk("t5_rst_done", done_o, 0);
    chk("t5_rst_id", id_o, 0);
    tick();
    rst_i = 1'b1;
    tick();
    chk("t5_regnt", gnt_o, 4'b0001);
    send(0, 1'b0, 1'b1);
    chk("t5_pd", pd_o, 0);
    chk("t5_done", done_o, 1);
    chk("t5_cnt", cnt_o, 0);
    chk("t5_abort", abort_o, 0);
    req_i = '0;
    tick();
    // idle-valid behaviour
    req_i = 4'b0001;
    tick();
    chk("t6_gnt", gnt_o, 4'b0001);
`ifdef PD_SCHED_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("t6_done%0d", i), done_o, 32'(i == 16));
    end
    chk("t6_abort", abort_o, 1);
`else
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk($sformatf("t6_done%0d", i), done_o, 0);
    end
    chk("t6_gnt_held", gnt_o, 4'b0001);
`endif
    req_i = '0;
    tick();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
